race_sequencer: RTL and testbench

Central game-flow controller for the Drag-Racing design. It sequences a round through the start-light countdown, the race, and the end-of-game result. It owns the per-player race timers and decides the winner. It replaces the scattered status glue between the menu, the light timer, the player timers and the scoreboard with one registered state machine, clocked in the pixel-clock domain.

---
 rtl/race_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_race_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/race_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : race_sequencer
// Description : Drag-race game-flow controller. Sequences IDLE -> COUNTDOWN
//               -> RACE -> DONE, owns both player race timers (sec.ms) and
//               latches the winner of the first finish.
//               Optional feature macro: RACE_FALSE_START_EN (key pressed in
//               COUNTDOWN latches a false-start flag and preloads a penalty).
// Revision    : 1.0 - initial release
// ============================================================================
module race_sequencer #(
  parameter int COUNTDOWN_S = 5,
  parameter int TICKS_PER_S = 1000,
  parameter int PENALTY_S   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_ms,
  input  logic        start_game,
  input  logic        restart,
  input  logic        p1_finish,
  input  logic        p2_finish,
  input  logic        p1_key,
  input  logic        p2_key,
  output logic [1:0]  state,
  output logic [3:0]  countdown_s,
  output logic        go,
  output logic        p1_enable,
  output logic        p2_enable,
  output logic [21:0] p1_time,
  output logic [21:0] p2_time,
  output logic [1:0]  winner,
  output logic        end_game,
  output logic        p1_false_start,
  output logic        p2_false_start
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_RACE      = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  localparam int                 c_ms_w    = (TICKS_PER_S > 1) ? $clog2(TICKS_PER_S) : 1;
  localparam logic [c_ms_w-1:0]  c_ms_last = c_ms_w'(TICKS_PER_S - 1);
  localparam logic [3:0]         c_cd_end  = 4'(COUNTDOWN_S);
`ifdef RACE_FALSE_START_EN
  localparam logic [21:0]        c_penalty = {12'(PENALTY_S), 10'd0};
`endif

  state_t            r_state, w_state_nxt;
  logic [c_ms_w-1:0] r_ms, w_ms_nxt;
  logic [3:0]        r_cd, w_cd_nxt;
  logic [21:0]       r_p1_time, w_p1_time_nxt;
  logic [21:0]       r_p2_time, w_p2_time_nxt;
  logic              r_p1_done, w_p1_done_nxt;
  logic              r_p2_done, w_p2_done_nxt;
  logic [1:0]        r_winner, w_winner_nxt;
  logic              r_fs1, w_fs1_nxt;
  logic              r_fs2, w_fs2_nxt;
  logic              r_go, w_go_nxt;
  logic              r_end, w_end_nxt;
  logic              r_p1_en, w_p1_en_nxt;
  logic              r_p2_en, w_p2_en_nxt;
  logic              w_p1_new, w_p2_new;

`ifndef RACE_FALSE_START_EN
  // Keys only matter when false-start detection is built in.
  logic w_unused_keys;
  assign w_unused_keys = p1_key ^ p2_key;
`endif

  // Advance a sec.ms timer by one millisecond, saturating at 4095.999.
  function automatic logic [21:0] f_time_inc(input logic [21:0] t);
    if (t[9:0] == 10'd999) begin
      if (t[21:10] == 12'hFFF) return t;
      else                     return {t[21:10] + 12'd1, 10'd0};
    end
    return {t[21:10], t[9:0] + 10'd1};
  endfunction

  // Next-state and next-output computation; restart overrides everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_ms_nxt      = r_ms;
    w_cd_nxt      = r_cd;
    w_p1_time_nxt = r_p1_time;
    w_p2_time_nxt = r_p2_time;
    w_p1_done_nxt = r_p1_done;
    w_p2_done_nxt = r_p2_done;
    w_winner_nxt  = r_winner;
    w_fs1_nxt     = r_fs1;
    w_fs2_nxt     = r_fs2;
    w_p1_new      = p1_finish & ~r_p1_done;
    w_p2_new      = p2_finish & ~r_p2_done;

    if (restart) begin
      w_state_nxt   = S_IDLE;
      w_ms_nxt      = '0;
      w_cd_nxt      = '0;
      w_p1_time_nxt = '0;
      w_p2_time_nxt = '0;
      w_p1_done_nxt = 1'b0;
      w_p2_done_nxt = 1'b0;
      w_winner_nxt  = 2'b00;
      w_fs1_nxt     = 1'b0;
      w_fs2_nxt     = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_game) begin
            w_state_nxt   = S_COUNTDOWN;
            w_ms_nxt      = '0;
            w_cd_nxt      = '0;
            w_p1_time_nxt = '0;
            w_p2_time_nxt = '0;
            w_p1_done_nxt = 1'b0;
            w_p2_done_nxt = 1'b0;
            w_winner_nxt  = 2'b00;
            w_fs1_nxt     = 1'b0;
            w_fs2_nxt     = 1'b0;
          end
        end
        S_COUNTDOWN: begin
          if (!start_game) begin
            // Menu withdrew the game: abandon the countdown.
            w_state_nxt = S_IDLE;
            w_ms_nxt    = '0;
            w_cd_nxt    = '0;
          end else begin
`ifdef RACE_FALSE_START_EN
            w_fs1_nxt = r_fs1 | p1_key;
            w_fs2_nxt = r_fs2 | p2_key;
`endif
            if (tick_ms) begin
              if (r_ms == c_ms_last) begin
                w_ms_nxt = '0;
                w_cd_nxt = r_cd + 4'd1;
                if (r_cd + 4'd1 == c_cd_end) begin
                  w_state_nxt = S_RACE;
`ifdef RACE_FALSE_START_EN
                  w_p1_time_nxt = w_fs1_nxt ? c_penalty : 22'd0;
                  w_p2_time_nxt = w_fs2_nxt ? c_penalty : 22'd0;
`else
                  w_p1_time_nxt = '0;
                  w_p2_time_nxt = '0;
`endif
                end
              end else begin
                w_ms_nxt = r_ms + c_ms_w'(1);
              end
            end
          end
        end
        S_RACE: begin
          // A tick in the same cycle as the finish level is not counted.
          if (w_p1_new)                  w_p1_done_nxt = 1'b1;
          else if (tick_ms && !r_p1_done) w_p1_time_nxt = f_time_inc(r_p1_time);
          if (w_p2_new)                  w_p2_done_nxt = 1'b1;
          else if (tick_ms && !r_p2_done) w_p2_time_nxt = f_time_inc(r_p2_time);
          if (r_winner == 2'b00 && (w_p1_new || w_p2_new))
            w_winner_nxt = {w_p2_new, w_p1_new};
          if (w_p1_done_nxt && w_p2_done_nxt)
            w_state_nxt = S_DONE;
        end
        default: ; // S_DONE: hold until restart
      endcase
    end

    w_go_nxt    = (w_state_nxt == S_RACE) || (w_state_nxt == S_DONE);
    w_end_nxt   = (w_state_nxt == S_DONE);
    w_p1_en_nxt = (w_state_nxt == S_RACE) && !w_p1_done_nxt;
    w_p2_en_nxt = (w_state_nxt == S_RACE) && !w_p2_done_nxt;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ms      <= '0;
      r_cd      <= '0;
      r_p1_time <= '0;
      r_p2_time <= '0;
      r_p1_done <= 1'b0;
      r_p2_done <= 1'b0;
      r_winner  <= 2'b00;
      r_fs1     <= 1'b0;
      r_fs2     <= 1'b0;
      r_go      <= 1'b0;
      r_end     <= 1'b0;
      r_p1_en   <= 1'b0;
      r_p2_en   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ms      <= w_ms_nxt;
      r_cd      <= w_cd_nxt;
      r_p1_time <= w_p1_time_nxt;
      r_p2_time <= w_p2_time_nxt;
      r_p1_done <= w_p1_done_nxt;
      r_p2_done <= w_p2_done_nxt;
      r_winner  <= w_winner_nxt;
      r_fs1     <= w_fs1_nxt;
      r_fs2     <= w_fs2_nxt;
      r_go      <= w_go_nxt;
      r_end     <= w_end_nxt;
      r_p1_en   <= w_p1_en_nxt;
      r_p2_en   <= w_p2_en_nxt;
    end
  end

  assign state          = r_state;
  assign countdown_s    = r_cd;
  assign go             = r_go;
  assign p1_enable      = r_p1_en;
  assign p2_enable      = r_p2_en;
  assign p1_time        = r_p1_time;
  assign p2_time        = r_p2_time;
  assign winner         = r_winner;
  assign end_game       = r_end;
  assign p1_false_start = r_fs1;
  assign p2_false_start = r_fs2;

endmodule
`default_nettype wire

// File: tb/tb_race_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_race_sequencer
// Description : Directed scoreboard bench for race_sequencer: reset, full
//               countdown, race result, tie, abort paths, reset mid-race and
//               false start (either build option).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_race_sequencer;

  logic        clk = 1'b0;
  logic        reset, tick_ms, start_game, restart;
  logic        p1_finish, p2_finish, p1_key, p2_key;
  logic [1:0]  state, winner;
  logic [3:0]  countdown_s;
  logic        go, p1_enable, p2_enable, end_game, p1_false_start, p2_false_start;
  logic [21:0] p1_time, p2_time;

  int checks = 0;
  int errors = 0;

  localparam int K_STATE = 0, K_CD = 1, K_GO = 2, K_P1EN = 3, K_P2EN = 4, K_P1T = 5,
                 K_P2T = 6, K_WIN = 7, K_END = 8, K_FS1 = 9, K_FS2 = 10;

`ifdef RACE_FALSE_START_EN
  localparam logic        c_fs_exp   = 1'b1;
  localparam logic [21:0] c_pen_time = {12'd1, 10'd0};
`else
  localparam logic        c_fs_exp   = 1'b0;
  localparam logic [21:0] c_pen_time = 22'd0;
`endif

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  race_sequencer dut (
    .clk(clk), .reset(reset), .tick_ms(tick_ms), .start_game(start_game),
    .restart(restart), .p1_finish(p1_finish), .p2_finish(p2_finish),
    .p1_key(p1_key), .p2_key(p2_key), .state(state), .countdown_s(countdown_s),
    .go(go), .p1_enable(p1_enable), .p2_enable(p2_enable), .p1_time(p1_time),
    .p2_time(p2_time), .winner(winner), .end_game(end_game),
    .p1_false_start(p1_false_start), .p2_false_start(p2_false_start)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      K_STATE: return {30'd0, state};
      K_CD:    return {28'd0, countdown_s};
      K_GO:    return {31'd0, go};
      K_P1EN:  return {31'd0, p1_enable};
      K_P2EN:  return {31'd0, p2_enable};
      K_P1T:   return {10'd0, p1_time};
      K_P2T:   return {10'd0, p2_time};
      K_WIN:   return {30'd0, winner};
      K_END:   return {31'd0, end_game};
      K_FS1:   return {31'd0, p1_false_start};
      K_FS2:   return {31'd0, p2_false_start};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cleared(input string pfx);
    push({pfx, "_state"}, K_STATE, 0);
    push({pfx, "_cd"},    K_CD,    0);
    push({pfx, "_go"},    K_GO,    0);
    push({pfx, "_p1en"},  K_P1EN,  0);
    push({pfx, "_p2en"},  K_P2EN,  0);
    push({pfx, "_p1t"},   K_P1T,   0);
    push({pfx, "_p2t"},   K_P2T,   0);
    push({pfx, "_win"},   K_WIN,   0);
    push({pfx, "_end"},   K_END,   0);
    push({pfx, "_fs1"},   K_FS1,   0);
    push({pfx, "_fs2"},   K_FS2,   0);
  endtask

  task automatic race_ticks(input int n);
    tick_ms = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    tick_ms = 1'b0;
  endtask

  // 5000 ticks from COUNTDOWN entry; RACE must appear after the last one.
  task automatic run_countdown(input bit detail);
    for (int i = 1; i <= 5000; i++) begin
      tick_ms = 1'b1;
      cycle();
      if (detail && (i % 1000 == 0) && i < 5000) begin
        push("cd_state", K_STATE, 1);
        push("cd_secs",  K_CD,    32'(i / 1000));
        drain();
      end
      if (detail && i == 4999) begin
        push("cd_4999_state", K_STATE, 1);
        push("cd_4999_go",    K_GO,    0);
        drain();
      end
    end
    tick_ms = 1'b0;
    push("race_entry_state", K_STATE, 2);
    push("race_entry_go",    K_GO,    1);
    push("race_entry_cd",    K_CD,    5);
    push("race_entry_p1en",  K_P1EN,  1);
    push("race_entry_p2en",  K_P2EN,  1);
    drain();
  endtask

  initial begin
    reset = 1'b1; tick_ms = 1'b0; start_game = 1'b0; restart = 1'b0;
    p1_finish = 1'b0; p2_finish = 1'b0; p1_key = 1'b0; p2_key = 1'b0;

    // Reset
    repeat (3) cycle();
    push_cleared("reset");
    drain();
    reset = 1'b0;

    // Ticks ignored in IDLE
    race_ticks(10);
    push_cleared("idle_ticks");
    drain();

    // Countdown
    start_game = 1'b1;
    cycle();
    push("cd_entry_state", K_STATE, 1);
    push("cd_entry_cd",    K_CD,    0);
    drain();
    run_countdown(1'b1);
    push("race_entry_p1t", K_P1T, 0);
    push("race_entry_p2t", K_P2T, 0);
    drain();

    // Race result: P1 after 3250 counted ms, P2 after 4000
    race_ticks(1000);
    push("race_1s_p1t", K_P1T, {12'd1, 10'd0});
    drain();
    race_ticks(2250);
    tick_ms = 1'b1; p1_finish = 1'b1;
    cycle();
    tick_ms = 1'b0;
    push("p1_fin_p1t",  K_P1T,   {12'd3, 10'd250});
    push("p1_fin_p1en", K_P1EN,  0);
    push("p1_fin_p2en", K_P2EN,  1);
    push("p1_fin_win",  K_WIN,   1);
    push("p1_fin_state",K_STATE, 2);
    drain();
    race_ticks(749);
    tick_ms = 1'b1; p2_finish = 1'b1;
    cycle();
    tick_ms = 1'b0;
    push("p2_fin_p1t",   K_P1T,   {12'd3, 10'd250});
    push("p2_fin_p2t",   K_P2T,   {12'd4, 10'd0});
    push("p2_fin_win",   K_WIN,   1);
    push("p2_fin_state", K_STATE, 3);
    push("p2_fin_end",   K_END,   1);
    push("p2_fin_go",    K_GO,    1);
    push("p2_fin_p2en",  K_P2EN,  0);
    drain();
    race_ticks(5);
    push("done_hold_p1t", K_P1T, {12'd3, 10'd250});
    push("done_hold_p2t", K_P2T, {12'd4, 10'd0});
    push("done_hold_win", K_WIN, 1);
    drain();
    p1_finish = 1'b0; p2_finish = 1'b0;
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    push_cleared("restart_done");
    drain();

    // Tie at 2000 ms
    cycle();
    push("tie_cd_state", K_STATE, 1);
    drain();
    run_countdown(1'b0);
    race_ticks(2000);
    tick_ms = 1'b1; p1_finish = 1'b1; p2_finish = 1'b1;
    cycle();
    tick_ms = 1'b0; p1_finish = 1'b0; p2_finish = 1'b0;
    push("tie_win",   K_WIN,   3);
    push("tie_p1t",   K_P1T,   {12'd2, 10'd0});
    push("tie_p2t",   K_P2T,   {12'd2, 10'd0});
    push("tie_state", K_STATE, 3);
    push("tie_end",   K_END,   1);
    drain();
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    push("tie_rst_state", K_STATE, 0);
    push("tie_rst_win",   K_WIN,   0);
    drain();

    // Abort by restart at tick 1500 of RACE
    cycle();
    run_countdown(1'b0);
    race_ticks(1499);
    tick_ms = 1'b1; restart = 1'b1;
    cycle();
    tick_ms = 1'b0; restart = 1'b0;
    push_cleared("abort_race");
    drain();

    // Abort by dropping start_game mid-countdown
    cycle();
    race_ticks(300);
    start_game = 1'b0;
    cycle();
    push("abort_cd_state", K_STATE, 0);
    push("abort_cd_go",    K_GO,    0);
    drain();

    // Reset in the middle of a race
    start_game = 1'b1;
    cycle();
    run_countdown(1'b0);
    race_ticks(100);
    reset = 1'b1;
    cycle();
    push_cleared("reset_mid_race");
    drain();
    reset = 1'b0;

    // False start by P2 during countdown
    cycle();
    push("fs_cd_state", K_STATE, 1);
    drain();
    p2_key = 1'b1;
    cycle();
    p2_key = 1'b0;
    push("fs_flag_p2", K_FS2, 32'(c_fs_exp));
    push("fs_flag_p1", K_FS1, 0);
    drain();
    run_countdown(1'b0);
    push("fs_entry_p2t", K_P2T, 32'(c_pen_time));
    push("fs_entry_p1t", K_P1T, 0);
    push("fs_entry_fs2", K_FS2, 32'(c_fs_exp));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
